// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the MIPS register file: two one-entry request buffers (ALU, load)
// share the single write port, plus a per-register busy scoreboard. Optional macro: WB_ROUND_ROBIN_EN.
module regfile_wb_arbiter #(
  parameter int S_AD        = 5,
  parameter int S_DATA      = 32,
  parameter int DIRECCIONES = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Reserve,
  input  logic [S_AD-1:0]        ResAddr,
  input  logic                   A_Valid,
  output logic                   A_Ready,
  input  logic [S_AD-1:0]        A_Addr,
  input  logic [S_DATA-1:0]      A_Data,
  input  logic                   B_Valid,
  output logic                   B_Ready,
  input  logic [S_AD-1:0]        B_Addr,
  input  logic [S_DATA-1:0]      B_Data,
  output logic                   WE,
  output logic [S_AD-1:0]        AWR,
  output logic [S_DATA-1:0]      DataIn,
  output logic [DIRECCIONES-1:0] Busy
);

  // Handshake: a source transfers on a rising edge where X_Valid && X_Ready;
  // X_Ready is high when its buffer is empty or being drained by this cycle's grant.
  logic                   full_a_q, full_a_d, full_b_q, full_b_d;
  logic [S_AD-1:0]        addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [S_DATA-1:0]      data_a_q, data_a_d, data_b_q, data_b_d;
  logic                   we_q, we_d;
  logic [S_AD-1:0]        awr_q, awr_d;
  logic [S_DATA-1:0]      wdata_q, wdata_d;
  logic [DIRECCIONES-1:0] busy_q, busy_d;
  logic                   grant_a, grant_b, any_grant, issue;
  logic                   xfer_a, xfer_b;
  logic [S_AD-1:0]        g_addr;
  logic [S_DATA-1:0]      g_data;

`ifdef WB_ROUND_ROBIN_EN
  // ptr_q = 0 favours A, 1 favours B when both buffers are full.
  logic ptr_q, ptr_d;
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (full_a_q && full_b_q) begin
`ifdef WB_ROUND_ROBIN_EN
      if (ptr_q) grant_b = 1'b1;
      else       grant_a = 1'b1;
`else
      grant_b = 1'b1;
`endif
    end else if (full_a_q) begin
      grant_a = 1'b1;
    end else if (full_b_q) begin
      grant_b = 1'b1;
    end
  end

  assign A_Ready   = rst_n & (~full_a_q | grant_a);
  assign B_Ready   = rst_n & (~full_b_q | grant_b);
  assign xfer_a    = A_Valid & A_Ready;
  assign xfer_b    = B_Valid & B_Ready;
  assign any_grant = grant_a | grant_b;
  assign g_addr    = grant_b ? addr_b_q : addr_a_q;
  assign g_data    = grant_b ? data_b_q : data_a_q;
  // Register 0 drains like any other entry but never produces a write.
  assign issue     = any_grant & (g_addr != '0);

  always_comb begin
    full_a_d = full_a_q;
    addr_a_d = addr_a_q;
    data_a_d = data_a_q;
    full_b_d = full_b_q;
    addr_b_d = addr_b_q;
    data_b_d = data_b_q;
    if (xfer_a) begin
      full_a_d = 1'b1;
      addr_a_d = A_Addr;
      data_a_d = A_Data;
    end else if (grant_a) begin
      full_a_d = 1'b0;
    end
    if (xfer_b) begin
      full_b_d = 1'b1;
      addr_b_d = B_Addr;
      data_b_d = B_Data;
    end else if (grant_b) begin
      full_b_d = 1'b0;
    end
  end

  always_comb begin
    we_d    = issue;
    awr_d   = any_grant ? g_addr : awr_q;
    wdata_d = any_grant ? g_data : wdata_q;
  end

  // Reservation is applied after the clear so a new producer on the same edge wins.
  always_comb begin
    busy_d = busy_q;
    if (issue) busy_d[g_addr] = 1'b0;
    if (Reserve && (ResAddr != '0)) busy_d[ResAddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

`ifdef WB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (grant_a)      ptr_d = 1'b1;
    else if (grant_b) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_a_q <= 1'b0;
      addr_a_q <= '0;
      data_a_q <= '0;
      full_b_q <= 1'b0;
      addr_b_q <= '0;
      data_b_q <= '0;
      we_q     <= 1'b0;
      awr_q    <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      full_a_q <= full_a_d;
      addr_a_q <= addr_a_d;
      data_a_q <= data_a_d;
      full_b_q <= full_b_d;
      addr_b_q <= addr_b_d;
      data_b_q <= data_b_d;
      we_q     <= we_d;
      awr_q    <= awr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign WE     = we_q;
  assign AWR    = awr_q;
  assign DataIn = wdata_q;
  assign Busy   = busy_q;

endmodule
